jk_ff_bank: RTL and testbench

Parametrised bank of WIDTH independent edge-triggered flip-flops sharing one clock, reset, enable and mode select; the successor to our single-bit JK flip-flop. Each cycle the bank applies one of four per-bit update rules (JK, SR, D, T), supports a synchronous parallel load, and reports which bits changed. It also keeps a sticky SR-conflict flag and a saturating count of cycles in which the bank changed. It sits in control/status paths wherever several JK-style state bits are currently instantiated one by one.

---
 rtl/jk_ff_bank.sv | 104 ++++++++++
 tb/tb_jk_ff_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH independent flip-flops sharing clock, reset, enable and
// mode select. Each bit follows a JK, SR, D or T update rule, with a
// synchronous parallel load. The bank also reports a registered change mask,
// a sticky SR-conflict flag and a saturating count of edges on which q changed.
module jk_ff_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter int unsigned           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] changed,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic             sr_err_q, sr_err_d;
    logic             sr_set;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign mode_s = mode_e'(mode);

    // Next-state selection: load beats enable-based update, otherwise hold.
    always_comb begin
        q_d    = q_q;
        sr_set = 1'b0;
        if (load) begin
            q_d = load_data;
        end else if (en) begin
            case (mode_s)
                MODE_JK: q_d = (j & ~q_q) | (~k & q_q);
                MODE_SR: begin
                    // S=R=1 holds the bit rather than forcing a value.
                    q_d    = (j & ~k) | (q_q & (j | ~k));
                    sr_set = |(j & k);
                end
                MODE_D:  q_d = j;
                MODE_T:  q_d = q_q ^ j;
                default: q_d = q_q;
            endcase
        end
    end

    // Change mask, saturating counter and sticky error (set beats clear).
    always_comb begin
        chg_d    = q_d ^ q_q;
        cnt_d    = cnt_q;
        if ((|chg_d) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        sr_err_d = sr_err_q;
        if (sr_set) begin
            sr_err_d = 1'b1;
        end else if (clr_err) begin
            sr_err_d = 1'b0;
        end
    end

    // State registers; qb is loaded from ~q_d so it never lags q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= RESET_VAL;
            qb_q     <= ~RESET_VAL;
            chg_q    <= '0;
            sr_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            q_q      <= q_d;
            qb_q     <= ~q_d;
            chg_q    <= chg_d;
            sr_err_q <= sr_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q       = q_q;
    assign qb      = qb_q;
    assign changed = chg_q;
    assign sr_err  = sr_err_q;
    assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench for jk_ff_bank: a wide-counter instance and a 2-bit-counter
// instance share all stimulus; expected values are hand-computed constants.
module tb_jk_ff_bank;

    logic       clk = 1'b0;
    logic       rst, en, load, clr_err;
    logic [1:0] mode;
    logic [7:0] j, k, load_data;

    logic [7:0]  q_a, qb_a, chg_a;
    logic        err_a;
    logic [15:0] cnt_a;
    logic [7:0]  q_b, qb_b, chg_b;
    logic        err_b;
    logic [1:0]  cnt_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_data(load_data), .clr_err(clr_err),
        .q(q_a), .qb(qb_a), .changed(chg_a), .sr_err(err_a), .chg_cnt(cnt_a)
    );

    jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_data(load_data), .clr_err(clr_err),
        .q(q_b), .qb(qb_b), .changed(chg_b), .sr_err(err_b), .chg_cnt(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [7:0] eq, input logic [7:0] ech,
                           input logic [15:0] ecnt);
        check_eq({tag, ".q"}, {24'd0, q_a}, {24'd0, eq});
        check_eq({tag, ".qb"}, {24'd0, qb_a}, {24'd0, ~eq});
        check_eq({tag, ".changed"}, {24'd0, chg_a}, {24'd0, ech});
        check_eq({tag, ".cnt"}, {16'd0, cnt_a}, {16'd0, ecnt});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; clr_err = 1'b0;
        mode = 2'b00; j = 8'h00; k = 8'h00; load_data = 8'h00;

        // Reset
        step();
        check_a("reset", 8'hA5, 8'h00, 16'd0);
        check_eq("reset.sr_err", {31'd0, err_a}, 32'd0);
        check_eq("reset.cnt_b", {30'd0, cnt_b}, 32'd0);

        // Load 00 to reach the JK starting point (counts as a change).
        rst = 1'b0; load = 1'b1; load_data = 8'h00;
        step();
        check_a("load00", 8'h00, 8'hA5, 16'd1);

        // JK
        load = 1'b0; en = 1'b1; mode = 2'b00; j = 8'hF0; k = 8'h0F;
        step();
        check_a("jk_set_clr", 8'hF0, 8'hF0, 16'd2);
        j = 8'hFF; k = 8'hFF;
        step();
        check_a("jk_toggle", 8'h0F, 8'hFF, 16'd3);
        j = 8'h00; k = 8'h00;
        step();
        check_a("jk_hold", 8'h0F, 8'h00, 16'd3);

        // SR conflict and sticky flag
        mode = 2'b01; j = 8'h03; k = 8'h01;
        step();
        check_a("sr_conflict", 8'h0F, 8'h00, 16'd3);
        check_eq("sr_conflict.err", {31'd0, err_a}, 32'd1);
        clr_err = 1'b1; j = 8'h00; k = 8'h00;
        step();
        check_eq("sr_clear.err", {31'd0, err_a}, 32'd0);
        j = 8'h80; k = 8'h80;
        step();
        check_eq("sr_set_wins.err", {31'd0, err_a}, 32'd1);
        check_eq("sr_set_wins.q", {24'd0, q_a}, 32'h0F);
        clr_err = 1'b0; en = 1'b0; j = 8'hFF; k = 8'hFF;
        step();
        check_eq("sr_sticky.err", {31'd0, err_a}, 32'd1);
        check_eq("sr_sticky.q", {24'd0, q_a}, 32'h0F);
        clr_err = 1'b1;
        step();
        check_eq("sr_en0_clear.err", {31'd0, err_a}, 32'd0);

        // Load during an SR conflict does not set the flag
        clr_err = 1'b0; load = 1'b1; load_data = 8'h00; en = 1'b1;
        step();
        check_a("sr_load", 8'h00, 8'h0F, 16'd4);
        check_eq("sr_load.err", {31'd0, err_a}, 32'd0);

        // D mode, k ignored
        load = 1'b0; mode = 2'b10; j = 8'h3C; k = 8'hFF;
        step();
        check_a("d_mode", 8'h3C, 8'h3C, 16'd5);

        // T mode twice
        mode = 2'b11; j = 8'hFF;
        step();
        check_a("t_first", 8'hC3, 8'hFF, 16'd6);
        step();
        check_a("t_second", 8'h3C, 8'hFF, 16'd7);

        // Load beats toggle
        load = 1'b1; load_data = 8'h77;
        step();
        check_a("load_prio", 8'h77, 8'h4B, 16'd8);

        // Disabled hold
        load = 1'b0; en = 1'b0;
        step();
        check_a("en0_hold", 8'h77, 8'h00, 16'd8);

        // Counter saturation on the 2-bit instance
        rst = 1'b1;
        step();
        check_eq("sat_rst.cnt_b", {30'd0, cnt_b}, 32'd0);
        rst = 1'b0; en = 1'b1; mode = 2'b11; j = 8'h01;
        step();
        check_eq("sat1.cnt_b", {30'd0, cnt_b}, 32'd1);
        check_eq("sat1.q_b", {24'd0, q_b}, 32'hA4);
        step();
        check_eq("sat2.cnt_b", {30'd0, cnt_b}, 32'd2);
        check_eq("sat2.q_b", {24'd0, q_b}, 32'hA5);
        step();
        check_eq("sat3.cnt_b", {30'd0, cnt_b}, 32'd3);
        check_eq("sat3.q_b", {24'd0, q_b}, 32'hA4);
        step();
        check_eq("sat4.cnt_b", {30'd0, cnt_b}, 32'd3);
        check_eq("sat4.q_b", {24'd0, q_b}, 32'hA5);
        step();
        check_eq("sat5.cnt_b", {30'd0, cnt_b}, 32'd3);
        check_eq("sat5.q_b", {24'd0, q_b}, 32'hA4);
        check_eq("sat5.chg_b", {24'd0, chg_b}, 32'h01);
        check_eq("sat5.cnt_a", {16'd0, cnt_a}, 32'd5);

        // Reset mid-stream beats load
        rst = 1'b1; load = 1'b1; load_data = 8'h77;
        step();
        check_a("mid_rst", 8'hA5, 8'h00, 16'd0);
        check_eq("mid_rst.q_b", {24'd0, q_b}, 32'hA5);
        check_eq("mid_rst.qb_b", {24'd0, qb_b}, 32'h5A);
        check_eq("mid_rst.cnt_b", {30'd0, cnt_b}, 32'd0);
        check_eq("mid_rst.err_b", {31'd0, err_b}, 32'd0);
        rst = 1'b0; load = 1'b0;
        step();
        check_a("resume", 8'hA4, 8'h01, 16'd1);
        check_eq("resume.cnt_b", {30'd0, cnt_b}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
